// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronised line, mid-bit sampling FSM and a
// single-entry holding register with valid/ready handoff and overrun flagging.
module uart_rx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int BIT_CLKS = CLK_HZ / BAUD;
    localparam int HALF     = BIT_CLKS / 2;
    localparam int CW       = $clog2(BIT_CLKS + 1);

    localparam logic [CW-1:0] BIT_LD  = CW'(BIT_CLKS);
    localparam logic [CW-1:0] HALF_LD = CW'(HALF);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    generate
        if (BIT_CLKS < 4) begin : g_bit_clks_check
            $error("uart_rx: CLK_HZ/BAUD must be at least 4");
        end
    endgenerate

    logic          rx_meta_p0;
    logic          rx_s;
    logic [2:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          stop_ok_p1;
    logic          expire;

    // A loaded count of N expires on the Nth following edge.
    assign expire = (cnt == CNT_ONE);
    assign busy   = (state != S_IDLE);

    // Stage p0: line synchroniser, idles high.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= rxd;
            rx_s       <= rx_meta_p0;
        end
    end

    // Stage p1: frame sequencing on the synchronised line.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shreg      <= 8'h00;
            stop_ok_p1 <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            stop_ok_p1 <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_s) begin
                        state <= S_START;
                        cnt   <= HALF_LD;
                    end
                end
                S_START: begin
                    if (expire) begin
                        if (rx_s) begin
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            cnt     <= BIT_LD;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (expire) begin
                        shreg <= {rx_s, shreg[7:1]};
                        cnt   <= BIT_LD;
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (expire) begin
                        if (rx_s) begin
                            state      <= S_IDLE;
                            stop_ok_p1 <= 1'b1;
                        end else begin
                            state     <= S_BREAK;
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_BREAK: begin
                    if (rx_s) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Stage p2: holding register; shreg is stable here since the FSM has only
    // just returned to IDLE and cannot shift for at least HALF clocks.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (stop_ok_p1) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
                overrun  <= rx_valid && !rx_ready;
            end else begin
                overrun <= 1'b0;
                if (rx_valid && rx_ready) begin
                    rx_valid <= 1'b0;
                end
            end
        end
    end

endmodule
